// File: rtl/gtxe2_chnl_cpll_seq_pkg.sv
// gtxe2_chnl_cpll_seq_pkg: shared state encodings, default sequencer timing constants and a max helper
package gtxe2_chnl_cpll_seq_pkg;
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PWRDN     = 3'd1,
    S_RESET     = 3'd2,
    S_WAIT_LOCK = 3'd3,
    S_RELEASE   = 3'd4,
    S_READY     = 3'd5,
    S_FAIL      = 3'd6
  } cpll_state_e;
  localparam int DEF_PD_CYCLES    = 16;
  localparam int DEF_RST_CYCLES   = 8;
  localparam int DEF_LOCK_STABLE  = 64;
  localparam int DEF_LOCK_TIMEOUT = 1024;
  localparam int DEF_RETRY_MAX    = 3;
  localparam int DEF_AUTO_START   = 1;
  function automatic int max3(int a, int b, int c);
    return a > b ? (a > c ? a : c) : (b > c ? b : c);
  endfunction
endpackage

// File: rtl/gtxe2_chnl_cpll_seq_if.sv
// gtxe2_chnl_cpll_seq_if: sequencer bus; master=sequencer (in: start, cpll_lock, cpll_refclk_lost; out: CPLL controls, tx_rst, rx_rst, done, fail, state, retry_cnt)
interface gtxe2_chnl_cpll_seq_if;
  import gtxe2_chnl_cpll_seq_pkg::*;
  logic        start;
  logic        cpll_lock;
  logic        cpll_refclk_lost;
  logic        CPLLPD;
  logic        CPLLRESET;
  logic        CPLLLOCKEN;
  logic        tx_rst;
  logic        rx_rst;
  logic        done;
  logic        fail;
  cpll_state_e state;
  logic [1:0]  retry_cnt;
  modport master (
    input  start, cpll_lock, cpll_refclk_lost,
    output CPLLPD, CPLLRESET, CPLLLOCKEN, tx_rst, rx_rst, done, fail, state, retry_cnt
  );
  modport slave (
    output start, cpll_lock, cpll_refclk_lost,
    input  CPLLPD, CPLLRESET, CPLLLOCKEN, tx_rst, rx_rst, done, fail, state, retry_cnt
  );
endinterface

// File: rtl/gtxe2_chnl_cpll_seq_sync_bit.sv
// gtxe2_sync_bit: 2-flop synchronizer with sync reset (clk, rst, d in; q out)
module gtxe2_sync_bit (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk)
    if (rst) {m, q} <= 2'b00;
    else {m, q} <= {d, m};
endmodule

// File: rtl/gtxe2_chnl_cpll_seq.sv
// gtxe2_chnl_cpll_seq: CPLL power-up/lock sequencer (clk, rst; bus.master carries start, lock inputs, CPLL controls and status)
module gtxe2_chnl_cpll_seq
  import gtxe2_chnl_cpll_seq_pkg::*;
#(
  parameter int PD_CYCLES    = DEF_PD_CYCLES,
  parameter int RST_CYCLES   = DEF_RST_CYCLES,
  parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int RETRY_MAX    = DEF_RETRY_MAX,
  parameter int AUTO_START   = DEF_AUTO_START
) (
  input logic clk,
  input logic rst,
  gtxe2_chnl_cpll_seq_if.master bus
);
  localparam int TW = $clog2(max3(PD_CYCLES, RST_CYCLES, LOCK_TIMEOUT) + 1);
  localparam int SW = $clog2(LOCK_STABLE + 1);
  cpll_state_e st, nxt;
  logic [1:0] retry, retry_nxt;
  logic [TW-1:0] tcnt;
  logic [SW-1:0] scnt;
  logic lock_s, lost_s, boot, auto_go, to, clr;
  gtxe2_sync_bit u_sync_lock (.clk(clk), .rst(rst), .d(bus.cpll_lock), .q(lock_s));
  gtxe2_sync_bit u_sync_lost (.clk(clk), .rst(rst), .d(bus.cpll_refclk_lost), .q(lost_s));
  // auto_go pulses on the second cycle after rst drops so IDLE is visible for one cycle
  always_ff @(posedge clk) begin
    boot    <= rst;
    auto_go <= boot && !rst && AUTO_START != 0;
  end
  always_comb begin
    nxt       = st;
    retry_nxt = retry;
    // refclk loss forces a timeout; a reached stable count suppresses the regular timeout
    to        = lost_s || (scnt != SW'(LOCK_STABLE) && tcnt == TW'(LOCK_TIMEOUT - 1));
    if (bus.start) begin
      nxt       = S_PWRDN;
      retry_nxt = '0;
    end else
      case (st)
        S_IDLE:      nxt = auto_go ? S_PWRDN : S_IDLE;
        S_PWRDN:     nxt = tcnt == TW'(PD_CYCLES - 1) ? S_RESET : S_PWRDN;
        S_RESET:     nxt = tcnt == TW'(RST_CYCLES - 1) ? S_WAIT_LOCK : S_RESET;
        S_WAIT_LOCK:
          if (to) begin
            retry_nxt = retry + 2'd1;
            nxt       = int'(retry_nxt) < RETRY_MAX ? S_PWRDN : S_FAIL;
          end else if (scnt == SW'(LOCK_STABLE))
            nxt = S_RELEASE;
        S_RELEASE:   nxt = S_READY;
        S_READY:     nxt = (!lock_s || lost_s) ? S_RESET : S_READY;
        S_FAIL:      nxt = S_FAIL;
        default:     nxt = S_IDLE;
      endcase
    clr = bus.start || nxt != st;
  end
  always_ff @(posedge clk)
    if (rst) begin
      st             <= S_IDLE;
      retry          <= '0;
      tcnt           <= '0;
      scnt           <= '0;
      bus.CPLLPD     <= 1'b1;
      bus.CPLLRESET  <= 1'b0;
      bus.CPLLLOCKEN <= 1'b0;
      bus.tx_rst     <= 1'b1;
      bus.rx_rst     <= 1'b1;
      bus.done       <= 1'b0;
      bus.fail       <= 1'b0;
    end else begin
      st             <= nxt;
      retry          <= retry_nxt;
      tcnt           <= clr ? '0 : tcnt + 1'b1;
      scnt           <= (clr || !lock_s) ? '0 : scnt + 1'b1;
      bus.CPLLPD     <= nxt inside {S_IDLE, S_PWRDN, S_FAIL};
      bus.CPLLRESET  <= nxt == S_RESET;
      bus.CPLLLOCKEN <= nxt inside {S_WAIT_LOCK, S_RELEASE, S_READY};
      bus.tx_rst     <= nxt != S_READY;
      bus.rx_rst     <= nxt != S_READY;
      bus.done       <= nxt == S_READY;
      bus.fail       <= nxt == S_FAIL;
    end
  assign bus.state     = st;
  assign bus.retry_cnt = retry;
endmodule

// File: tb/tb_gtxe2_chnl_cpll_seq.sv
// tb_gtxe2_chnl_cpll_seq: scoreboard bench for the CPLL sequencer
module tb_gtxe2_chnl_cpll_seq;
  import gtxe2_chnl_cpll_seq_pkg::*;
  typedef struct {
    string      tag;
    logic [11:0] v;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  exp_t q[$];
  gtxe2_chnl_cpll_seq_if bus();
  gtxe2_chnl_cpll_seq #(
    .PD_CYCLES(4), .RST_CYCLES(2), .LOCK_STABLE(3),
    .LOCK_TIMEOUT(20), .RETRY_MAX(2), .AUTO_START(1)
  ) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // {state, retry_cnt, CPLLPD, CPLLRESET, CPLLLOCKEN, tx_rst, rx_rst, done, fail}
  function automatic logic [11:0] exp_vec(cpll_state_e s, logic [1:0] r);
    logic [6:0] o;
    case (s)
      S_IDLE, S_PWRDN:        o = 7'b1001100;
      S_RESET:                o = 7'b0101100;
      S_WAIT_LOCK, S_RELEASE: o = 7'b0011100;
      S_READY:                o = 7'b0010010;
      S_FAIL:                 o = 7'b1001101;
      default:                o = 7'bxxxxxxx;
    endcase
    return {s, r, o};
  endfunction
  function automatic logic [11:0] obs();
    return {bus.state, bus.retry_cnt, bus.CPLLPD, bus.CPLLRESET, bus.CPLLLOCKEN,
            bus.tx_rst, bus.rx_rst, bus.done, bus.fail};
  endfunction
  task automatic check(string tag, logic [11:0] got, logic [11:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask
  task automatic push_exp(string tag, cpll_state_e s, logic [1:0] r);
    q.push_back('{tag, exp_vec(s, r)});
  endtask
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      check(e.tag, obs(), e.v);
    end
  endtask
  task automatic wait_state(string tag, cpll_state_e s, int budget);
    int n = 0;
    while (bus.state != s && n < budget) begin
      tick();
      n++;
    end
    if (bus.state != s) check(tag, 12'(bus.state), 12'(s));
  endtask
  task automatic pulse_start(string tag);
    bus.start = 1'b1;
    push_exp(tag, S_PWRDN, 2'd0);
    tick();
    bus.start = 1'b0;
  endtask
  initial begin
    bus.start = 1'b0;
    bus.cpll_lock = 1'b0;
    bus.cpll_refclk_lost = 1'b0;
    push_exp("rst_vals", S_IDLE, 0);
    repeat (3) tick();
    rst = 1'b0;
    push_exp("idle_e0", S_IDLE, 0);
    tick();
    push_exp("pwrdn_e1", S_PWRDN, 0);
    tick();
    repeat (3) begin push_exp("pwrdn_hold", S_PWRDN, 0); tick(); end
    repeat (2) begin push_exp("reset_hold", S_RESET, 0); tick(); end
    repeat (4) begin push_exp("wait_nolock", S_WAIT_LOCK, 0); tick(); end
    bus.cpll_lock = 1'b1;
    repeat (5) begin push_exp("wait_sync", S_WAIT_LOCK, 0); tick(); end
    push_exp("release", S_RELEASE, 0);
    tick();
    push_exp("ready", S_READY, 0);
    tick();
    bus.cpll_lock = 1'b0;
    repeat (2) begin push_exp("ready_drop", S_READY, 0); tick(); end
    push_exp("lost_lock", S_RESET, 0);
    tick();
    bus.cpll_lock = 1'b1;
    push_exp("relock_reset", S_RESET, 0);
    tick();
    wait_state("relock", S_READY, 30);
    push_exp("relock_ready", S_READY, 0);
    tick();
    pulse_start("start_ready");
    bus.cpll_lock = 1'b0;
    wait_state("glitch_wait", S_WAIT_LOCK, 30);
    bus.cpll_lock = 1'b1;
    repeat (2) begin push_exp("glitch_hi", S_WAIT_LOCK, 0); tick(); end
    bus.cpll_lock = 1'b0;
    push_exp("glitch_lo", S_WAIT_LOCK, 0);
    tick();
    bus.cpll_lock = 1'b1;
    repeat (5) begin push_exp("glitch_restart", S_WAIT_LOCK, 0); tick(); end
    push_exp("glitch_release", S_RELEASE, 0);
    tick();
    push_exp("glitch_ready", S_READY, 0);
    tick();
    bus.cpll_lock = 1'b0;
    pulse_start("start_to");
    wait_state("to1_wait", S_WAIT_LOCK, 30);
    repeat (19) begin push_exp("to1_wait_hold", S_WAIT_LOCK, 0); tick(); end
    push_exp("to1_retry", S_PWRDN, 1);
    tick();
    wait_state("to2_wait", S_WAIT_LOCK, 30);
    repeat (19) begin push_exp("to2_wait_hold", S_WAIT_LOCK, 1); tick(); end
    push_exp("to2_fail", S_FAIL, 2);
    tick();
    repeat (3) begin push_exp("fail_hold", S_FAIL, 2); tick(); end
    pulse_start("start_fail");
    wait_state("st_wait1", S_WAIT_LOCK, 30);
    repeat (19) begin push_exp("st_wait1_hold", S_WAIT_LOCK, 0); tick(); end
    push_exp("st_retry", S_PWRDN, 1);
    tick();
    wait_state("st_wait2", S_WAIT_LOCK, 30);
    repeat (19) begin push_exp("st_wait2_hold", S_WAIT_LOCK, 1); tick(); end
    pulse_start("start_beats_to");
    wait_state("rst_mid_wait", S_RESET, 30);
    rst = 1'b1;
    push_exp("rst_mid", S_IDLE, 0);
    tick();
    rst = 1'b0;
    push_exp("rst_mid_idle", S_IDLE, 0);
    tick();
    push_exp("rst_mid_auto", S_PWRDN, 0);
    tick();
    bus.cpll_lock = 1'b1;
    wait_state("rl_ready_wait", S_READY, 60);
    bus.cpll_refclk_lost = 1'b1;
    repeat (2) begin push_exp("rl_ready_sync", S_READY, 0); tick(); end
    push_exp("rl_ready_reset", S_RESET, 0);
    tick();
    bus.cpll_refclk_lost = 1'b0;
    wait_state("rl_reready", S_READY, 60);
    push_exp("rl_reready_retry", S_READY, 0);
    tick();
    pulse_start("start_rl_wait");
    wait_state("rl_wait_wait", S_WAIT_LOCK, 30);
    bus.cpll_refclk_lost = 1'b1;
    repeat (2) begin push_exp("rl_wait_sync", S_WAIT_LOCK, 0); tick(); end
    push_exp("rl_wait_to", S_PWRDN, 1);
    tick();
    bus.cpll_refclk_lost = 1'b0;
    wait_state("rl_retry_ready", S_READY, 60);
    push_exp("rl_retry_kept", S_READY, 1);
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
